// File: rtl/uart_load_if.sv
// ---------------------------------------------------------------------------
// uart_load_if
// Groups the UART download handshake, the pipeline-busy status and the
// memory-ownership outputs of uart_load_ctrl.
//   master : UART programmer / pipeline side (drives the requests, observes
//            the controller outputs)
//   slave  : uart_load_ctrl
// Signals:
//   uart_start        level, download session requested
//   uart_done         one-cycle end-of-download pulse
//   uart_write_enable one word written per high cycle
//   uart_addr         word address, MSB selects data (1) / instruction (0)
//   pipeline_busy     later stage still has a memory access in flight
//   hazard_control    fetch-stage command (NORMAL / NO_OP)
//   uart_disable      1 = pipeline owns memory, 0 = UART owns memory
//   pc_reset          one-cycle PC-to-zero request
//   load_active       high in every state except RUN
//   imem_words        instruction words written this/last session
//   dmem_words        data words written this/last session
//   load_error        last session aborted on idle timeout
// ---------------------------------------------------------------------------
interface uart_load_if #(
    parameter int ROM_DEPTH      = 14,
    parameter int HAZD_CTL_WIDTH = 2
);
    logic                      uart_start;
    logic                      uart_done;
    logic                      uart_write_enable;
    logic [ROM_DEPTH:0]        uart_addr;
    logic                      pipeline_busy;
    logic [HAZD_CTL_WIDTH-1:0] hazard_control;
    logic                      uart_disable;
    logic                      pc_reset;
    logic                      load_active;
    logic [15:0]               imem_words;
    logic [15:0]               dmem_words;
    logic                      load_error;

    modport master (
        output uart_start, uart_done, uart_write_enable, uart_addr, pipeline_busy,
        input  hazard_control, uart_disable, pc_reset, load_active,
               imem_words, dmem_words, load_error
    );

    modport slave (
        input  uart_start, uart_done, uart_write_enable, uart_addr, pipeline_busy,
        output hazard_control, uart_disable, pc_reset, load_active,
               imem_words, dmem_words, load_error
    );
endinterface

// File: rtl/uart_load_ctrl.sv
// ---------------------------------------------------------------------------
// uart_load_ctrl
// Hands instruction/data memory from the pipeline to a UART programmer and
// back. A session stalls fetch (NO_OP), waits for the pipeline to drain,
// gives memory to the UART, counts written words per memory half, and on
// uart_done (or idle timeout) pulses pc_reset and resumes execution from 0.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    uart_load_if.slave (handshake inputs, status/command outputs)
// All outputs are registered copies of the decode of the next state, so
// they always equal the decode of the current state.
// ---------------------------------------------------------------------------
module uart_load_ctrl #(
    parameter int ROM_DEPTH      = 14,
    parameter int DRAIN_CYCLES   = 4,
    parameter int TIMEOUT        = 1_000_000,
    parameter int HAZD_CTL_WIDTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    uart_load_if.slave   bus
);

    localparam logic [HAZD_CTL_WIDTH-1:0] HC_NORMAL = HAZD_CTL_WIDTH'(0);
    localparam logic [HAZD_CTL_WIDTH-1:0] HC_NO_OP  = HAZD_CTL_WIDTH'(1);

    localparam int DRAIN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam int IDLE_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [DRAIN_W-1:0] DRAIN_MAX = DRAIN_W'(DRAIN_CYCLES);
    localparam logic [IDLE_W-1:0]  IDLE_MAX  = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_FINISH = 3'd3,
        ST_RESUME = 3'd4
    } state_t;

    state_t                    state_r;
    state_t                    state_s;
    logic                      timeout_s;
    logic                      enter_drain_s;
    logic                      enter_load_s;
    logic                      write_s;

    logic [DRAIN_W-1:0]        drain_cnt_r;
    logic [IDLE_W-1:0]         idle_cnt_r;
    logic                      rearm_wait_r;

    logic [HAZD_CTL_WIDTH-1:0] hazard_control_s;
    logic                      uart_disable_s;
    logic                      pc_reset_s;
    logic                      load_active_s;

    logic [HAZD_CTL_WIDTH-1:0] hazard_control_r;
    logic                      uart_disable_r;
    logic                      pc_reset_r;
    logic                      load_active_r;
    logic [15:0]               imem_words_r;
    logic [15:0]               dmem_words_r;
    logic                      load_error_r;

    // Next-state logic; uart_done and writes only matter in LOAD.
    always_comb begin
        state_s   = state_r;
        timeout_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                // rearm_wait_r blocks a start level still held from the last session
                if (bus.uart_start && !rearm_wait_r) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!bus.uart_start) begin
                    state_s = ST_RUN;
                end else if ((drain_cnt_r == DRAIN_MAX) && !bus.pipeline_busy) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_LOAD: begin
                if (bus.uart_done) begin
                    state_s = ST_FINISH;
                end else if (!bus.uart_write_enable && (idle_cnt_r == IDLE_MAX)) begin
                    state_s   = ST_FINISH;
                    timeout_s = 1'b1;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_FINISH: state_s = ST_RESUME;
            ST_RESUME: state_s = ST_RUN;
            default:   state_s = ST_RUN;
        endcase
    end

    // Transition qualifiers shared by the counters.
    always_comb begin
        enter_drain_s = (state_r == ST_RUN)   && (state_s == ST_DRAIN);
        enter_load_s  = (state_r == ST_DRAIN) && (state_s == ST_LOAD);
        write_s       = (state_r == ST_LOAD)  && bus.uart_write_enable;
    end

    // Output decode of the next state, registered below.
    always_comb begin
        hazard_control_s = HC_NO_OP;
        uart_disable_s   = 1'b1;
        pc_reset_s       = 1'b0;
        load_active_s    = 1'b1;
        case (state_s)
            ST_RUN: begin
                hazard_control_s = HC_NORMAL;
                load_active_s    = 1'b0;
            end
            ST_DRAIN:  uart_disable_s = 1'b1;
            ST_LOAD:   uart_disable_s = 1'b0;
            ST_FINISH: pc_reset_s     = 1'b1;
            ST_RESUME: pc_reset_s     = 1'b0;
            default: begin
                hazard_control_s = HC_NORMAL;
                load_active_s    = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= ST_RUN;
            hazard_control_r <= HC_NORMAL;
            uart_disable_r   <= 1'b1;
            pc_reset_r       <= 1'b0;
            load_active_r    <= 1'b0;
        end else begin
            state_r          <= state_s;
            hazard_control_r <= hazard_control_s;
            uart_disable_r   <= uart_disable_s;
            pc_reset_r       <= pc_reset_s;
            load_active_r    <= load_active_s;
        end
    end

    // Drain counter: cleared on DRAIN entry, saturates at DRAIN_CYCLES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt_r <= '0;
        end else if (enter_drain_s) begin
            drain_cnt_r <= '0;
        end else if ((state_r == ST_DRAIN) && (drain_cnt_r != DRAIN_MAX)) begin
            drain_cnt_r <= drain_cnt_r + DRAIN_W'(1);
        end else begin
            drain_cnt_r <= drain_cnt_r;
        end
    end

    // Idle counter: cycles since the last write (or LOAD entry).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_r <= '0;
        end else if (enter_load_s || write_s) begin
            idle_cnt_r <= '0;
        end else if ((state_r == ST_LOAD) && (idle_cnt_r != IDLE_MAX)) begin
            idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
        end else begin
            idle_cnt_r <= idle_cnt_r;
        end
    end

    // Per-half word counters and sticky timeout flag, cleared per session.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_words_r <= 16'h0000;
            dmem_words_r <= 16'h0000;
            load_error_r <= 1'b0;
        end else if (enter_drain_s) begin
            imem_words_r <= 16'h0000;
            dmem_words_r <= 16'h0000;
            load_error_r <= 1'b0;
        end else begin
            if (write_s && bus.uart_addr[ROM_DEPTH] && (dmem_words_r != 16'hFFFF)) begin
                dmem_words_r <= dmem_words_r + 16'h0001;
            end else begin
                dmem_words_r <= dmem_words_r;
            end
            if (write_s && !bus.uart_addr[ROM_DEPTH] && (imem_words_r != 16'hFFFF)) begin
                imem_words_r <= imem_words_r + 16'h0001;
            end else begin
                imem_words_r <= imem_words_r;
            end
            load_error_r <= load_error_r | timeout_s;
        end
    end

    // Re-arm: a session start must be preceded by uart_start sampled low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rearm_wait_r <= 1'b0;
        end else if (!bus.uart_start) begin
            rearm_wait_r <= 1'b0;
        end else if (enter_drain_s) begin
            rearm_wait_r <= 1'b1;
        end else begin
            rearm_wait_r <= rearm_wait_r;
        end
    end

    assign bus.hazard_control = hazard_control_r;
    assign bus.uart_disable   = uart_disable_r;
    assign bus.pc_reset       = pc_reset_r;
    assign bus.load_active    = load_active_r;
    assign bus.imem_words     = imem_words_r;
    assign bus.dmem_words     = dmem_words_r;
    assign bus.load_error     = load_error_r;

endmodule

// File: tb/tb_uart_load_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_load_ctrl
// Directed self-checking bench for uart_load_ctrl (TIMEOUT=16, DRAIN_CYCLES=4).
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_uart_load_ctrl;

    localparam int ROM_DEPTH = 14;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    uart_load_if #(.ROM_DEPTH(ROM_DEPTH), .HAZD_CTL_WIDTH(2)) bus ();

    uart_load_ctrl #(
        .ROM_DEPTH      (ROM_DEPTH),
        .DRAIN_CYCLES   (4),
        .TIMEOUT        (16),
        .HAZD_CTL_WIDTH (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_word(input logic [ROM_DEPTH:0] addr);
        bus.uart_write_enable = 1'b1;
        bus.uart_addr         = addr;
        step(1);
        bus.uart_write_enable = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_hc"},   32'(bus.hazard_control), 32'd0);
        check_eq({tag, "_ud"},   32'(bus.uart_disable),   32'd1);
        check_eq({tag, "_pcr"},  32'(bus.pc_reset),       32'd0);
        check_eq({tag, "_la"},   32'(bus.load_active),    32'd0);
        check_eq({tag, "_imem"}, 32'(bus.imem_words),     32'd0);
        check_eq({tag, "_dmem"}, 32'(bus.dmem_words),     32'd0);
        check_eq({tag, "_err"},  32'(bus.load_error),     32'd0);
    endtask

    initial begin
        n_checks              = 0;
        n_errors              = 0;
        rst_n                 = 1'b0;
        bus.uart_start        = 1'b0;
        bus.uart_done         = 1'b0;
        bus.uart_write_enable = 1'b0;
        bus.uart_addr         = '0;
        bus.pipeline_busy     = 1'b0;

        // reset values
        step(2);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step(2);
        check_eq("idle_la", 32'(bus.load_active), 32'd0);

        // stray done / write in RUN are ignored
        bus.uart_done         = 1'b1;
        bus.uart_write_enable = 1'b1;
        step(1);
        bus.uart_done         = 1'b0;
        bus.uart_write_enable = 1'b0;
        check_eq("run_ignore_la",   32'(bus.load_active), 32'd0);
        check_eq("run_ignore_imem", 32'(bus.imem_words),  32'd0);

        // session 1: drain timing, 3 imem + 2 dmem writes, done
        bus.uart_start = 1'b1;
        step(1);
        check_eq("s1_drain_hc", 32'(bus.hazard_control), 32'd1);
        check_eq("s1_drain_la", 32'(bus.load_active),    32'd1);
        step(4);
        check_eq("s1_ud_before", 32'(bus.uart_disable), 32'd1);
        step(1);
        check_eq("s1_ud_load", 32'(bus.uart_disable), 32'd0);
        write_word(15'h0000);
        write_word(15'h0001);
        write_word(15'h0002);
        write_word(15'h4000);
        write_word(15'h4001);
        bus.uart_done = 1'b1;
        step(1);
        bus.uart_done  = 1'b0;
        bus.uart_start = 1'b0;
        check_eq("s1_fin_pcr",  32'(bus.pc_reset),       32'd1);
        check_eq("s1_fin_ud",   32'(bus.uart_disable),   32'd1);
        check_eq("s1_fin_hc",   32'(bus.hazard_control), 32'd1);
        check_eq("s1_imem",     32'(bus.imem_words),     32'd3);
        check_eq("s1_dmem",     32'(bus.dmem_words),     32'd2);
        step(1);
        check_eq("s1_res_pcr",  32'(bus.pc_reset),       32'd0);
        check_eq("s1_res_hc",   32'(bus.hazard_control), 32'd1);
        step(1);
        check_eq("s1_run_hc",   32'(bus.hazard_control), 32'd0);
        check_eq("s1_run_la",   32'(bus.load_active),    32'd0);
        check_eq("s1_run_pcr",  32'(bus.pc_reset),       32'd0);

        // session 2: pipeline busy delays LOAD, then idle timeout
        bus.pipeline_busy = 1'b1;
        bus.uart_start    = 1'b1;
        step(1);
        check_eq("s2_clr_imem", 32'(bus.imem_words), 32'd0);
        check_eq("s2_clr_dmem", 32'(bus.dmem_words), 32'd0);
        step(10);
        check_eq("s2_busy_ud", 32'(bus.uart_disable), 32'd1);
        check_eq("s2_busy_la", 32'(bus.load_active),  32'd1);
        bus.pipeline_busy = 1'b0;
        step(1);
        check_eq("s2_load_ud", 32'(bus.uart_disable), 32'd0);
        write_word(15'h0005);
        step(15);
        check_eq("s2_pre_to_err", 32'(bus.load_error),   32'd0);
        check_eq("s2_pre_to_ud",  32'(bus.uart_disable), 32'd0);
        step(1);
        check_eq("s2_to_err",  32'(bus.load_error), 32'd1);
        check_eq("s2_to_pcr",  32'(bus.pc_reset),   32'd1);
        check_eq("s2_to_imem", 32'(bus.imem_words), 32'd1);
        step(2);
        check_eq("s2_run_hc",  32'(bus.hazard_control), 32'd0);
        check_eq("s2_run_err", 32'(bus.load_error),     32'd1);
        // start still high: must not re-enter
        step(3);
        check_eq("s2_norearm_la", 32'(bus.load_active), 32'd0);
        bus.uart_start = 1'b0;
        step(1);
        bus.uart_start = 1'b1;
        step(1);
        check_eq("s3_start_la",  32'(bus.load_active), 32'd1);
        check_eq("s3_clr_err",   32'(bus.load_error),  32'd0);

        // session 3: reset mid-LOAD after 5 writes
        step(5);
        check_eq("s3_load_ud", 32'(bus.uart_disable), 32'd0);
        for (int i = 0; i < 5; i++) begin
            write_word(15'(i));
        end
        check_eq("s3_imem5", 32'(bus.imem_words), 32'd5);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midload_rst");
        bus.uart_start = 1'b0;
        step(2);
        check_eq("rst_hold_pcr", 32'(bus.pc_reset), 32'd0);
        rst_n = 1'b1;
        step(2);
        check_eq("post_rst_pcr", 32'(bus.pc_reset),    32'd0);
        check_eq("post_rst_la",  32'(bus.load_active), 32'd0);

        // session 4: done coincident with a write, start held through RESUME
        bus.uart_start = 1'b1;
        step(6);
        check_eq("s4_load_ud", 32'(bus.uart_disable), 32'd0);
        write_word(15'h0010);
        bus.uart_write_enable = 1'b1;
        bus.uart_addr         = 15'h4000;
        bus.uart_done         = 1'b1;
        step(1);
        bus.uart_write_enable = 1'b0;
        bus.uart_done         = 1'b0;
        check_eq("s4_fin_pcr", 32'(bus.pc_reset),   32'd1);
        check_eq("s4_imem",    32'(bus.imem_words), 32'd1);
        check_eq("s4_dmem",    32'(bus.dmem_words), 32'd1);
        step(4);
        check_eq("s4_norearm_la", 32'(bus.load_active),    32'd0);
        check_eq("s4_norearm_hc", 32'(bus.hazard_control), 32'd0);
        bus.uart_start = 1'b0;
        step(1);
        bus.uart_start = 1'b1;
        step(1);
        check_eq("s5_start_hc", 32'(bus.hazard_control), 32'd1);

        // start falls in DRAIN: back to RUN, no pc_reset, counters kept
        bus.uart_start = 1'b0;
        step(1);
        check_eq("abort_la",   32'(bus.load_active),    32'd0);
        check_eq("abort_hc",   32'(bus.hazard_control), 32'd0);
        check_eq("abort_pcr",  32'(bus.pc_reset),       32'd0);
        check_eq("abort_ud",   32'(bus.uart_disable),   32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
